// File: rtl/exe_fwd_unit_pkg.sv
// Shared definitions for the EXE forwarding/hazard controller:
// operand mux select encodings and the select priority helper.
package exe_fwd_unit_pkg;

    // EXE operand mux select encodings
    localparam logic [1:0] SEL_RF  = 2'b00;  // register file value
    localparam logic [1:0] SEL_MEM = 2'b01;  // ALU result held in the MEM stage
    localparam logic [1:0] SEL_WB  = 2'b10;  // value being written back

    // Default register-number width (16 architectural registers)
    localparam int DEF_REG_ADDR_W = 4;

    // The MEM stage holds the newer result, so it wins over WB.
    function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return SEL_MEM;
        end else if (wb_hit) begin
            return SEL_WB;
        end else begin
            return SEL_RF;
        end
    endfunction

endpackage

// File: rtl/exe_fwd_unit_fwd_sel.sv
// Operand select for one EXE source: compares the source register against
// the MEM and WB shadow slots and picks the youngest usable producer.
module exe_fwd_unit_fwd_sel
    import exe_fwd_unit_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic [REG_ADDR_W-1:0] src,
    input  logic                  use_src,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  mem_mem_r_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic                  wb_wb_en,
    output logic [1:0]            sel
);

    logic mem_hit;
    logic wb_hit;

    // A load in MEM has no data yet, so it never qualifies as a MEM forward;
    // with forwarding disabled the register file is always selected.
    always_comb begin
        mem_hit = use_src & mem_wb_en & ~mem_mem_r_en & (mem_dest == src);
        wb_hit  = use_src & wb_wb_en & (wb_dest == src);
        sel     = FWD_EN ? fwd_pick(mem_hit, wb_hit) : SEL_RF;
    end

endmodule

// File: rtl/exe_fwd_unit.sv
// Forwarding/hazard controller sitting in front of the EXE operand muxes.
// Keeps a 3-slot shadow of the EXE/MEM/WB destination info, derives the
// operand selects from the slots only, and raises a load-use (or, with
// forwarding disabled, any RAW) stall against the instruction in ID.
module exe_fwd_unit
    import exe_fwd_unit_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter bit FWD_EN     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_use_src1,
    input  logic                  id_use_src2,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    output logic [1:0]            Sel_src1,
    output logic [1:0]            Sel_src2,
    output logic                  hazard
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic                  use1;
        logic                  use2;
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_r_en;
    } exe_slot_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
        logic                  mem_r_en;
    } mem_slot_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic                  wb_en;
    } wb_slot_t;

    // A bubble has every enable low; register numbers are zeroed too so a
    // bubble is a single well-defined value.
    localparam exe_slot_t EXE_BUBBLE = '0;
    localparam mem_slot_t MEM_BUBBLE = '0;
    localparam wb_slot_t  WB_BUBBLE  = '0;

    exe_slot_t exe_q;
    mem_slot_t mem_q;
    wb_slot_t  wb_q;
    exe_slot_t id_slot;

    logic id_hits_exe;
    logic id_hits_mem;

    // Pack the ID-stage fields into the shape of an EXE slot.
    always_comb begin
        id_slot          = EXE_BUBBLE;
        id_slot.src1     = id_src1;
        id_slot.src2     = id_src2;
        id_slot.use1     = id_use_src1;
        id_slot.use2     = id_use_src2;
        id_slot.dest     = id_dest;
        id_slot.wb_en    = id_wb_en;
        id_slot.mem_r_en = id_mem_r_en;
    end

    // Stall decision: only a load in EXE blocks when forwarding is on;
    // without forwarding any pending write in EXE or MEM blocks.
    always_comb begin
        id_hits_exe = exe_q.wb_en &
                      ((id_use_src1 & (id_src1 == exe_q.dest)) |
                       (id_use_src2 & (id_src2 == exe_q.dest)));
        id_hits_mem = mem_q.wb_en &
                      ((id_use_src1 & (id_src1 == mem_q.dest)) |
                       (id_use_src2 & (id_src2 == mem_q.dest)));
        hazard      = FWD_EN ? (id_hits_exe & exe_q.mem_r_en)
                             : (id_hits_exe | id_hits_mem);
    end

    // Shadow pipeline: reset clears, freeze holds, otherwise shift forward
    // and load a bubble into EXE on flush or stall.
    always_ff @(posedge clk) begin
        if (!rst) begin
            exe_q <= EXE_BUBBLE;
            mem_q <= MEM_BUBBLE;
            wb_q  <= WB_BUBBLE;
        end else if (!freeze) begin
            wb_q.dest      <= mem_q.dest;
            wb_q.wb_en     <= mem_q.wb_en;
            mem_q.dest     <= exe_q.dest;
            mem_q.wb_en    <= exe_q.wb_en;
            mem_q.mem_r_en <= exe_q.mem_r_en;
            exe_q          <= (flush | hazard) ? EXE_BUBBLE : id_slot;
        end
    end

    exe_fwd_unit_fwd_sel #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) u_sel_src1 (
        .src          (exe_q.src1),
        .use_src      (exe_q.use1),
        .mem_dest     (mem_q.dest),
        .mem_wb_en    (mem_q.wb_en),
        .mem_mem_r_en (mem_q.mem_r_en),
        .wb_dest      (wb_q.dest),
        .wb_wb_en     (wb_q.wb_en),
        .sel          (Sel_src1)
    );

    exe_fwd_unit_fwd_sel #(
        .REG_ADDR_W (REG_ADDR_W),
        .FWD_EN     (FWD_EN)
    ) u_sel_src2 (
        .src          (exe_q.src2),
        .use_src      (exe_q.use2),
        .mem_dest     (mem_q.dest),
        .mem_wb_en    (mem_q.wb_en),
        .mem_mem_r_en (mem_q.mem_r_en),
        .wb_dest      (wb_q.dest),
        .wb_wb_en     (wb_q.wb_en),
        .sel          (Sel_src2)
    );

    // The stall keeps a load from ever reaching MEM while its consumer sits
    // in EXE; a hit here means that protection has been bypassed.
    logic load_in_mem_hits_exe;
    assign load_in_mem_hits_exe = mem_q.wb_en & mem_q.mem_r_en &
                                  ((exe_q.use1 & (exe_q.src1 == mem_q.dest)) |
                                   (exe_q.use2 & (exe_q.src2 == mem_q.dest)));

    a_no_load_fwd: assert property (@(posedge clk) disable iff (!rst)
                                    !(FWD_EN && load_in_mem_hits_exe));

endmodule
